// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage core.
// Detects load-use hazards, freezes the pipe during data-memory waits,
// sequences branch flushes (including one deferred across a freeze) and
// produces the EX-stage operand forwarding selects.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       id_ra_addr,
    input  logic [4:0]       id_rt_addr,
    input  logic             id_use_ra,
    input  logic             id_use_rt,
    input  logic [4:0]       ex_dest,
    input  logic             ex_dm_read,
    input  logic             ex_reg_write,
    input  logic [4:0]       mem_dest,
    input  logic             mem_dm_read,
    input  logic             mem_reg_write,
    input  logic [4:0]       wb_dest,
    input  logic             wb_reg_write,
    input  logic             mem_access,
    input  logic             dm_ready,
    input  logic             branch_taken,
    output logic             enable_pc,
    output logic             hold_REG1,
    output logic             hold_REG2,
    output logic             hold_REG3,
    output logic             hold_REG4,
    output logic             do_flush_REG1,
    output logic             do_flush_REG2,
    output logic [1:0]       fwd_sel_ra,
    output logic [1:0]       fwd_sel_rt,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count
);

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
    // Last counter value before the wait is declared dead.
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    state_t           state_r;
    logic [WC_W-1:0]  wait_cnt_r;
    logic             branch_pending_r;
    logic             mem_timeout_r;
    logic [CNT_W-1:0] stall_count_r;
    logic [4:0]       ex_ra_r;
    logic [4:0]       ex_rt_r;

    logic lu_s;
    logic mw_s;
    logic freeze_s;
    logic branch_s;
    logic timeout_s;

    // Forwarding select for one EX source: MEM beats WB, loads in MEM take DM_out.
    function automatic logic [1:0] fwd_pick(
        input logic [4:0] src,
        input logic [4:0] m_dest,
        input logic       m_wr,
        input logic       m_ld,
        input logic [4:0] w_dest,
        input logic       w_wr
    );
        logic [1:0] sel;
        if (m_wr && (m_dest == src)) begin
            sel = m_ld ? 2'd3 : 2'd1;
        end else if (w_wr && (w_dest == src)) begin
            sel = 2'd2;
        end else begin
            sel = 2'd0;
        end
        return sel;
    endfunction

    assign lu_s = ex_dm_read & ex_reg_write &
                  ((id_use_ra & (ex_dest == id_ra_addr)) |
                   (id_use_rt & (ex_dest == id_rt_addr)));
    assign mw_s      = mem_access & ~dm_ready;
    assign branch_s  = branch_taken | branch_pending_r;
    assign timeout_s = (state_r == ST_MEM_WAIT) & freeze_s & (wait_cnt_r == WC_LAST);

    // Freeze decision: once waiting, only dm_ready releases the pipe.
    always_comb begin
        freeze_s = 1'b0;
        case (state_r)
            ST_MEM_WAIT: freeze_s = ~dm_ready;
            ST_RUN,
            ST_LU_STALL: freeze_s = mw_s;
            default:     freeze_s = mw_s;
        endcase
    end

    // Pipe controls: freeze > load-use > branch flush; quiet while in reset.
    always_comb begin
        enable_pc     = 1'b1;
        hold_REG1     = 1'b0;
        hold_REG2     = 1'b0;
        hold_REG3     = 1'b0;
        hold_REG4     = 1'b0;
        do_flush_REG1 = 1'b0;
        do_flush_REG2 = 1'b0;
        fwd_sel_ra    = 2'd0;
        fwd_sel_rt    = 2'd0;
        if (!reset) begin
            enable_pc = 1'b1;
        end else begin
            fwd_sel_ra = fwd_pick(ex_ra_r, mem_dest, mem_reg_write, mem_dm_read,
                                  wb_dest, wb_reg_write);
            fwd_sel_rt = fwd_pick(ex_rt_r, mem_dest, mem_reg_write, mem_dm_read,
                                  wb_dest, wb_reg_write);
            if (freeze_s) begin
                enable_pc = 1'b0;
                hold_REG1 = 1'b1;
                hold_REG2 = 1'b1;
                hold_REG3 = 1'b1;
                hold_REG4 = 1'b1;
            end else if (lu_s) begin
                enable_pc     = 1'b0;
                hold_REG1     = 1'b1;
                do_flush_REG2 = 1'b1;
            end else if (branch_s) begin
                do_flush_REG1 = 1'b1;
            end else begin
                do_flush_REG1 = 1'b0;
            end
        end
    end

    // Sequencer state, wait counter, deferred branch and sticky timeout flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r          <= ST_RUN;
            wait_cnt_r       <= {WC_W{1'b0}};
            branch_pending_r <= 1'b0;
            mem_timeout_r    <= 1'b0;
        end else if (freeze_s) begin
            branch_pending_r <= branch_pending_r | branch_taken;
            if (timeout_s) begin
                mem_timeout_r <= 1'b1;
                wait_cnt_r    <= {WC_W{1'b0}};
                state_r       <= ST_RUN;
            end else begin
                wait_cnt_r <= wait_cnt_r + WC_W'(1);
                state_r    <= ST_MEM_WAIT;
            end
        end else begin
            wait_cnt_r <= {WC_W{1'b0}};
            if (lu_s) begin
                state_r <= ST_LU_STALL;
            end else begin
                state_r <= ST_RUN;
                if (branch_s) begin
                    branch_pending_r <= 1'b0;
                end else begin
                    branch_pending_r <= branch_pending_r;
                end
            end
        end
    end

    // Saturating count of cycles in which the pc was held.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_count_r <= {CNT_W{1'b0}};
        end else if (!enable_pc && (stall_count_r != {CNT_W{1'b1}})) begin
            stall_count_r <= stall_count_r + CNT_W'(1);
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    // Shadow of the EX source addresses, tracking REG2 advance and flush.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ex_ra_r <= 5'd0;
            ex_rt_r <= 5'd0;
        end else if (do_flush_REG2) begin
            ex_ra_r <= 5'd0;
            ex_rt_r <= 5'd0;
        end else if (!hold_REG2) begin
            ex_ra_r <= id_ra_addr;
            ex_rt_r <= id_rt_addr;
        end else begin
            ex_ra_r <= ex_ra_r;
            ex_rt_r <= ex_rt_r;
        end
    end

    assign mem_timeout = mem_timeout_r;
    assign stall_count = stall_count_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// traffic, all checked against a cycle-level behavioural model.
module tb_hazard_ctrl;

    localparam int TMO = 15;
    localparam int CW  = 4;

    logic clock = 1'b0;
    logic reset;
    logic [4:0] id_ra_addr, id_rt_addr, ex_dest, mem_dest, wb_dest;
    logic id_use_ra, id_use_rt, ex_dm_read, ex_reg_write;
    logic mem_dm_read, mem_reg_write, wb_reg_write;
    logic mem_access, dm_ready, branch_taken;
    logic enable_pc, hold_REG1, hold_REG2, hold_REG3, hold_REG4;
    logic do_flush_REG1, do_flush_REG2, mem_timeout;
    logic [1:0] fwd_sel_ra, fwd_sel_rt;
    logic [CW-1:0] stall_count;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit m_wait;
    int m_wn;
    bit m_pend;
    bit m_tmo;
    int m_stalls;
    int m_exra;
    int m_exrt;

    always #5 clock = ~clock;

    hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset),
        .id_ra_addr(id_ra_addr), .id_rt_addr(id_rt_addr),
        .id_use_ra(id_use_ra), .id_use_rt(id_use_rt),
        .ex_dest(ex_dest), .ex_dm_read(ex_dm_read), .ex_reg_write(ex_reg_write),
        .mem_dest(mem_dest), .mem_dm_read(mem_dm_read), .mem_reg_write(mem_reg_write),
        .wb_dest(wb_dest), .wb_reg_write(wb_reg_write),
        .mem_access(mem_access), .dm_ready(dm_ready), .branch_taken(branch_taken),
        .enable_pc(enable_pc),
        .hold_REG1(hold_REG1), .hold_REG2(hold_REG2),
        .hold_REG3(hold_REG3), .hold_REG4(hold_REG4),
        .do_flush_REG1(do_flush_REG1), .do_flush_REG2(do_flush_REG2),
        .fwd_sel_ra(fwd_sel_ra), .fwd_sel_rt(fwd_sel_rt),
        .mem_timeout(mem_timeout), .stall_count(stall_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int fwd_exp(input int src);
        if (mem_reg_write && int'(mem_dest) == src) return mem_dm_read ? 3 : 1;
        if (wb_reg_write && int'(wb_dest) == src) return 2;
        return 0;
    endfunction

    task automatic clr();
        id_ra_addr = 5'd0; id_rt_addr = 5'd0; id_use_ra = 1'b0; id_use_rt = 1'b0;
        ex_dest = 5'd0; ex_dm_read = 1'b0; ex_reg_write = 1'b0;
        mem_dest = 5'd0; mem_dm_read = 1'b0; mem_reg_write = 1'b0;
        wb_dest = 5'd0; wb_reg_write = 1'b0;
        mem_access = 1'b0; dm_ready = 1'b0; branch_taken = 1'b0;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model.
    task automatic cycle();
        bit lu, mw, frz, br, e_pc, e_f1, e_f2;
        @(negedge clock); #1;
        lu  = ex_dm_read && ex_reg_write &&
              ((id_use_ra && ex_dest == id_ra_addr) || (id_use_rt && ex_dest == id_rt_addr));
        mw  = mem_access && !dm_ready;
        frz = m_wait ? !dm_ready : mw;
        br  = branch_taken || m_pend;
        e_pc = !(frz || lu);
        e_f1 = !frz && !lu && br;
        e_f2 = !frz && lu;
        chk("enable_pc", enable_pc, e_pc);
        chk("hold_REG1", hold_REG1, frz || lu);
        chk("hold_REG2", hold_REG2, frz);
        chk("hold_REG3", hold_REG3, frz);
        chk("hold_REG4", hold_REG4, frz);
        chk("do_flush_REG1", do_flush_REG1, e_f1);
        chk("do_flush_REG2", do_flush_REG2, e_f2);
        chk("fwd_sel_ra", fwd_sel_ra, fwd_exp(m_exra));
        chk("fwd_sel_rt", fwd_sel_rt, fwd_exp(m_exrt));
        chk("mem_timeout", mem_timeout, m_tmo);
        chk("stall_count", stall_count, m_stalls);
        if (!e_pc && m_stalls < (1 << CW) - 1) m_stalls++;
        if (frz) begin
            if (branch_taken) m_pend = 1'b1;
            m_wn++;
            if (m_wait && m_wn == TMO) begin
                m_tmo = 1'b1; m_wait = 1'b0; m_wn = 0;
            end else begin
                m_wait = 1'b1;
            end
        end else begin
            m_wait = 1'b0; m_wn = 0;
            if (e_f1) m_pend = 1'b0;
        end
        if (e_f2) begin
            m_exra = 0; m_exrt = 0;
        end else if (!frz) begin
            m_exra = int'(id_ra_addr); m_exrt = int'(id_rt_addr);
        end
        @(posedge clock); #1;
    endtask

    // Reset with hazard-provoking inputs present; outputs must stay quiet.
    task automatic do_reset();
        mem_access = 1'b1; dm_ready = 1'b0; mem_reg_write = 1'b1; mem_dest = 5'd0;
        branch_taken = 1'b1;
        reset = 1'b0;
        #1;
        chk("rst_enable_pc", enable_pc, 1);
        chk("rst_holds", {hold_REG1, hold_REG2, hold_REG3, hold_REG4}, 0);
        chk("rst_flushes", {do_flush_REG1, do_flush_REG2}, 0);
        chk("rst_fwd", {fwd_sel_ra, fwd_sel_rt}, 0);
        chk("rst_timeout", mem_timeout, 0);
        chk("rst_stall_count", stall_count, 0);
        m_wait = 1'b0; m_wn = 0; m_pend = 1'b0; m_tmo = 1'b0;
        m_stalls = 0; m_exra = 0; m_exrt = 0;
        @(negedge clock);
        clr();
        reset = 1'b1;
        @(posedge clock); #1;
    endtask

    initial begin
        clr();
        reset = 1'b1;
        #2;
        do_reset();

        // Load-use on ra=r3: one stall cycle
        clr(); ex_dm_read = 1'b1; ex_reg_write = 1'b1; ex_dest = 5'd3;
        id_use_ra = 1'b1; id_ra_addr = 5'd3;
        cycle();
        chk("lu_stall_count", stall_count, 1);
        // Load now in MEM, dependent still in ID
        clr(); mem_dm_read = 1'b1; mem_reg_write = 1'b1; mem_dest = 5'd3;
        id_use_ra = 1'b1; id_ra_addr = 5'd3;
        cycle();
        // Dependent in EX with a load writing r3 in MEM: DM_out select
        clr(); mem_dm_read = 1'b1; mem_reg_write = 1'b1; mem_dest = 5'd3;
        id_ra_addr = 5'd3;
        cycle();

        // Same load, ID reads only rt=r4: no stall
        clr(); ex_dm_read = 1'b1; ex_reg_write = 1'b1; ex_dest = 5'd3;
        id_use_rt = 1'b1; id_rt_addr = 5'd4; id_ra_addr = 5'd3;
        cycle();

        // Three wait cycles then ready
        do_reset();
        clr(); mem_access = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        dm_ready = 1'b1;
        cycle();
        chk("mw_stall_count", stall_count, 3);
        chk("mw_no_timeout", mem_timeout, 0);

        // Branch during freeze, flushed only in the release cycle
        clr(); mem_access = 1'b1; branch_taken = 1'b1;
        cycle();
        branch_taken = 1'b0;
        cycle();
        dm_ready = 1'b1;
        cycle();
        clr();
        cycle();

        // Timeout after TMO cycles without dm_ready
        clr(); mem_access = 1'b1;
        for (int i = 0; i < TMO; i++) cycle();
        chk("timeout_flag", mem_timeout, 1);
        clr();
        cycle();
        chk("timeout_sticky", mem_timeout, 1);

        // Forwarding priority for r5
        clr(); id_ra_addr = 5'd5; id_rt_addr = 5'd5;
        cycle();
        mem_reg_write = 1'b1; mem_dest = 5'd5; wb_reg_write = 1'b1; wb_dest = 5'd5;
        cycle();
        mem_reg_write = 1'b0;
        cycle();

        // Reset in the middle of a wait with a pending branch
        clr(); mem_access = 1'b1; branch_taken = 1'b1;
        cycle();
        branch_taken = 1'b0;
        cycle();
        do_reset();
        clr();
        cycle();

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            id_ra_addr    = 5'($urandom_range(0, 3));
            id_rt_addr    = 5'($urandom_range(0, 3));
            id_use_ra     = 1'($urandom);
            id_use_rt     = 1'($urandom);
            ex_dest       = 5'($urandom_range(0, 3));
            ex_dm_read    = 1'($urandom);
            ex_reg_write  = 1'($urandom);
            mem_dest      = 5'($urandom_range(0, 3));
            mem_dm_read   = 1'($urandom);
            mem_reg_write = 1'($urandom);
            wb_dest       = 5'($urandom_range(0, 3));
            wb_reg_write  = 1'($urandom);
            mem_access    = ($urandom_range(0, 3) == 0);
            dm_ready      = ($urandom_range(0, 2) != 0);
            branch_taken  = ($urandom_range(0, 3) == 0);
            cycle();
            if (n == 300) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
